// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped, two-read/two-write branch target buffer for the fetch
//   stage. Looks up both fetched PCs against registered state, merges the
//   hits with the direction predictor to choose the next fetch PC, and
//   learns targets from up to two resolved taken branches per cycle.
//
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   if_inst{1,2}_pc/_valid       fetch slots being looked up
//   inst{1,2}_predict(_valid)    direction predictor outputs per slot
//   branch_{valid,result,pc,target}{1,2}   resolved branches (write ports)
//   inst{1,2}_hit/_target        per-slot lookup result (target 0 on miss)
//   next_pc, next_pc_redirect    next fetch PC and whether it is a taken target
//   slot2_squash                 slot 1 predicted taken, slot 2 is dropped
module branch_target_buffer #(
    parameter int BTB_SIZE = 32,
    parameter int TAG_BITS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] if_inst1_pc,
    input  logic        inst1_valid,
    input  logic [63:0] if_inst2_pc,
    input  logic        inst2_valid,
    input  logic        inst1_predict,
    input  logic        inst1_predict_valid,
    input  logic        inst2_predict,
    input  logic        inst2_predict_valid,
    input  logic        branch_valid1,
    input  logic        branch_result1,
    input  logic [63:0] branch_pc1,
    input  logic [63:0] branch_target1,
    input  logic        branch_valid2,
    input  logic        branch_result2,
    input  logic [63:0] branch_pc2,
    input  logic [63:0] branch_target2,
    output logic        inst1_hit,
    output logic [63:0] inst1_target,
    output logic        inst2_hit,
    output logic [63:0] inst2_target,
    output logic [63:0] next_pc,
    output logic        next_pc_redirect,
    output logic        slot2_squash
);

    localparam int IW = $clog2(BTB_SIZE);

    logic [BTB_SIZE-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q    [BTB_SIZE];
    logic [TAG_BITS-1:0] tag_d    [BTB_SIZE];
    logic [63:0]         target_q [BTB_SIZE];
    logic [63:0]         target_d [BTB_SIZE];

    logic [IW-1:0]       rd_idx1, rd_idx2, wr_idx1, wr_idx2;
    logic [TAG_BITS-1:0] rd_tag1, rd_tag2, wr_tag1, wr_tag2;
    logic                take1, take2;

    // Only the index and tag slices of the branch PCs are stored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{branch_pc1[63:IW+TAG_BITS+2], branch_pc1[1:0],
                              branch_pc2[63:IW+TAG_BITS+2], branch_pc2[1:0]};

    assign rd_idx1 = if_inst1_pc[IW+1:2];
    assign rd_idx2 = if_inst2_pc[IW+1:2];
    assign wr_idx1 = branch_pc1[IW+1:2];
    assign wr_idx2 = branch_pc2[IW+1:2];
    assign rd_tag1 = if_inst1_pc[IW+TAG_BITS+1:IW+2];
    assign rd_tag2 = if_inst2_pc[IW+TAG_BITS+1:IW+2];
    assign wr_tag1 = branch_pc1[IW+TAG_BITS+1:IW+2];
    assign wr_tag2 = branch_pc2[IW+TAG_BITS+1:IW+2];

    // Port 2 is applied after port 1 so it wins on an index collision.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (branch_valid1 && branch_result1) begin
            valid_d[wr_idx1]  = 1'b1;
            tag_d[wr_idx1]    = wr_tag1;
            target_d[wr_idx1] = branch_target1;
        end
        if (branch_valid2 && branch_result2) begin
            valid_d[wr_idx2]  = 1'b1;
            tag_d[wr_idx2]    = wr_tag2;
            target_d[wr_idx2] = branch_target2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    // Hits are masked during reset so the first reset cycle already looks
    // empty, before the clearing edge has happened.
    always_comb begin
        inst1_hit = ~reset & inst1_valid & valid_q[rd_idx1] & (tag_q[rd_idx1] == rd_tag1);
        inst2_hit = ~reset & inst2_valid & valid_q[rd_idx2] & (tag_q[rd_idx2] == rd_tag2);
        inst1_target = inst1_hit ? target_q[rd_idx1] : 64'h0;
        inst2_target = inst2_hit ? target_q[rd_idx2] : 64'h0;
        take1 = inst1_hit & inst1_predict_valid & inst1_predict;
        take2 = inst2_hit & inst2_predict_valid & inst2_predict;

        next_pc          = if_inst1_pc;
        next_pc_redirect = 1'b0;
        slot2_squash     = 1'b0;
        if (take1) begin
            next_pc          = inst1_target;
            next_pc_redirect = 1'b1;
            slot2_squash     = 1'b1;
        end else if (take2) begin
            next_pc          = inst2_target;
            next_pc_redirect = 1'b1;
        end else if (inst2_valid) begin
            next_pc = if_inst2_pc + 64'd4;
        end else if (inst1_valid) begin
            next_pc = if_inst1_pc + 64'd4;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    localparam int BTB_SIZE = 32;
    localparam int TAG_BITS = 10;
    localparam int IW       = $clog2(BTB_SIZE);

    logic        clock, reset;
    logic [63:0] if_inst1_pc, if_inst2_pc;
    logic        inst1_valid, inst2_valid;
    logic        inst1_predict, inst1_predict_valid, inst2_predict, inst2_predict_valid;
    logic        branch_valid1, branch_result1, branch_valid2, branch_result2;
    logic [63:0] branch_pc1, branch_target1, branch_pc2, branch_target2;
    logic        inst1_hit, inst2_hit, next_pc_redirect, slot2_squash;
    logic [63:0] inst1_target, inst2_target, next_pc;

    int checks = 0;
    int errors = 0;

    branch_target_buffer #(.BTB_SIZE(BTB_SIZE), .TAG_BITS(TAG_BITS)) dut (
        .clock(clock), .reset(reset),
        .if_inst1_pc(if_inst1_pc), .inst1_valid(inst1_valid),
        .if_inst2_pc(if_inst2_pc), .inst2_valid(inst2_valid),
        .inst1_predict(inst1_predict), .inst1_predict_valid(inst1_predict_valid),
        .inst2_predict(inst2_predict), .inst2_predict_valid(inst2_predict_valid),
        .branch_valid1(branch_valid1), .branch_result1(branch_result1),
        .branch_pc1(branch_pc1), .branch_target1(branch_target1),
        .branch_valid2(branch_valid2), .branch_result2(branch_result2),
        .branch_pc2(branch_pc2), .branch_target2(branch_target2),
        .inst1_hit(inst1_hit), .inst1_target(inst1_target),
        .inst2_hit(inst2_hit), .inst2_target(inst2_target),
        .next_pc(next_pc), .next_pc_redirect(next_pc_redirect),
        .slot2_squash(slot2_squash)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference table: one slot per index, holding the tag and target of the
    // last taken branch that mapped there.
    bit          m_valid  [BTB_SIZE];
    logic [63:0] m_tag    [BTB_SIZE];
    logic [63:0] m_target [BTB_SIZE];

    function automatic int midx(input logic [63:0] pc);
        return int'((pc / 64'd4) % 64'(BTB_SIZE));
    endfunction

    function automatic logic [63:0] mtag(input logic [63:0] pc);
        return (pc / (64'd4 * 64'(BTB_SIZE))) % (64'd1 << TAG_BITS);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Compare every output against the reference for the current inputs.
    task automatic look(input string name);
        logic        h1, h2, tk1, tk2;
        logic [63:0] t1, t2, np;
        #1;
        h1 = !reset && inst1_valid && m_valid[midx(if_inst1_pc)] && m_tag[midx(if_inst1_pc)] == mtag(if_inst1_pc);
        h2 = !reset && inst2_valid && m_valid[midx(if_inst2_pc)] && m_tag[midx(if_inst2_pc)] == mtag(if_inst2_pc);
        t1 = h1 ? m_target[midx(if_inst1_pc)] : 64'h0;
        t2 = h2 ? m_target[midx(if_inst2_pc)] : 64'h0;
        tk1 = h1 && inst1_predict_valid && inst1_predict;
        tk2 = h2 && inst2_predict_valid && inst2_predict;
        if (tk1)              np = t1;
        else if (tk2)         np = t2;
        else if (inst2_valid) np = if_inst2_pc + 64'd4;
        else if (inst1_valid) np = if_inst1_pc + 64'd4;
        else                  np = if_inst1_pc;
        chk({name, ".hit1"},     64'(inst1_hit),        64'(h1));
        chk({name, ".target1"},  inst1_target,          t1);
        chk({name, ".hit2"},     64'(inst2_hit),        64'(h2));
        chk({name, ".target2"},  inst2_target,          t2);
        chk({name, ".next_pc"},  next_pc,               np);
        chk({name, ".redirect"}, 64'(next_pc_redirect), 64'(tk1 || tk2));
        chk({name, ".squash"},   64'(slot2_squash),     64'(tk1));
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else begin
            if (branch_valid1 && branch_result1) begin
                m_valid[midx(branch_pc1)]  = 1'b1;
                m_tag[midx(branch_pc1)]    = mtag(branch_pc1);
                m_target[midx(branch_pc1)] = branch_target1;
            end
            if (branch_valid2 && branch_result2) begin
                m_valid[midx(branch_pc2)]  = 1'b1;
                m_tag[midx(branch_pc2)]    = mtag(branch_pc2);
                m_target[midx(branch_pc2)] = branch_target2;
            end
        end
        @(negedge clock);
    endtask

    task automatic fetch(input logic [63:0] p1, input logic [63:0] p2, input logic v1, input logic v2,
                         input logic pr1, input logic pv1, input logic pr2, input logic pv2);
        if_inst1_pc = p1; if_inst2_pc = p2; inst1_valid = v1; inst2_valid = v2;
        inst1_predict = pr1; inst1_predict_valid = pv1;
        inst2_predict = pr2; inst2_predict_valid = pv2;
    endtask

    task automatic br(input logic v1, input logic r1, input logic [63:0] p1, input logic [63:0] t1,
                      input logic v2, input logic r2, input logic [63:0] p2, input logic [63:0] t2);
        branch_valid1 = v1; branch_result1 = r1; branch_pc1 = p1; branch_target1 = t1;
        branch_valid2 = v2; branch_result2 = r2; branch_pc2 = p2; branch_target2 = t2;
    endtask

    function automatic logic [63:0] rpc();
        logic [63:0] base;
        case ($urandom_range(0, 3))
            0:       base = 64'h0;
            1:       base = 64'h1000;
            2:       base = 64'hFFFF_FFFF_FFFF_FF00;
            default: base = 64'h0000_0000_0004_0000;
        endcase
        return base + 64'($urandom_range(0, 63)) * 64'd4;
    endfunction

    initial begin
        foreach (m_valid[i]) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0;
        end
        reset = 1'b1;
        fetch(64'h100, 64'h104, 1, 1, 0, 0, 0, 0);
        br(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        look("in_reset");
        chk("in_reset.hit1_zero", 64'(inst1_hit), 64'h0);
        tick();
        reset = 1'b0;

        // 1: empty table, sequential next PC
        look("t1");
        chk("t1.next_pc", next_pc, 64'h108);
        chk("t1.redirect", 64'(next_pc_redirect), 64'h0);
        tick();

        // 2: learn 0x100 -> 0x400, then predict taken in slot 1
        br(1, 1, 64'h100, 64'h400, 0, 0, 0, 0);
        look("t2_wr");
        tick();
        br(0, 0, 0, 0, 0, 0, 0, 0);
        fetch(64'h100, 64'h104, 1, 1, 1, 1, 0, 0);
        look("t2");
        chk("t2.hit1", 64'(inst1_hit), 64'h1);
        chk("t2.next_pc", next_pc, 64'h400);
        chk("t2.squash", 64'(slot2_squash), 64'h1);
        tick();

        // 3: slot 1 not taken, slot 2 taken
        br(0, 0, 0, 0, 1, 1, 64'h104, 64'h800);
        look("t3_wr");
        tick();
        br(0, 0, 0, 0, 0, 0, 0, 0);
        fetch(64'h100, 64'h104, 1, 1, 0, 1, 1, 1);
        look("t3");
        chk("t3.next_pc", next_pc, 64'h800);
        chk("t3.squash", 64'(slot2_squash), 64'h0);
        chk("t3.redirect", 64'(next_pc_redirect), 64'h1);
        tick();

        // 4: same-index double write, port 2 wins; not-taken leaves it alone
        br(1, 1, 64'h100, 64'h400, 1, 1, 64'h100, 64'h500);
        look("t4_wr");
        tick();
        br(1, 0, 64'h100, 64'h999, 0, 0, 0, 0);
        look("t4_nt");
        tick();
        br(0, 0, 0, 0, 0, 0, 0, 0);
        fetch(64'h100, 64'h104, 1, 1, 1, 1, 0, 0);
        look("t4");
        chk("t4.target1", inst1_target, 64'h500);
        tick();

        // 5: alias replaces the entry
        br(1, 1, 64'h100, 64'h400, 0, 0, 0, 0);
        tick();
        br(1, 1, 64'h100 + 4 * BTB_SIZE, 64'h900, 0, 0, 0, 0);
        tick();
        br(0, 0, 0, 0, 0, 0, 0, 0);
        fetch(64'h100, 64'h100 + 4 * BTB_SIZE, 1, 1, 0, 0, 0, 0);
        look("t5");
        chk("t5.hit1", 64'(inst1_hit), 64'h0);
        chk("t5.target2", inst2_target, 64'h900);
        tick();

        // 6: no write-to-read bypass, then reset overrides pending writes
        br(1, 1, 64'h200, 64'h640, 0, 0, 0, 0);
        fetch(64'h200, 64'h204, 1, 1, 1, 1, 0, 0);
        look("t6_same");
        chk("t6_same.hit1", 64'(inst1_hit), 64'h0);
        tick();
        br(0, 0, 0, 0, 0, 0, 0, 0);
        look("t6_next");
        chk("t6_next.next_pc", next_pc, 64'h640);
        tick();
        reset = 1'b1;
        br(1, 1, 64'h300, 64'h700, 1, 1, 64'h104, 64'h720);
        fetch(64'h200, 64'h104, 1, 1, 1, 1, 1, 1);
        look("t6_rst");
        chk("t6_rst.hit1", 64'(inst1_hit), 64'h0);
        tick();
        reset = 1'b0;
        br(0, 0, 0, 0, 0, 0, 0, 0);
        fetch(64'h300, 64'h104, 1, 1, 1, 1, 1, 1);
        look("t6_post");
        chk("t6_post.hit2", 64'(inst2_hit), 64'h0);
        tick();

        // Wrap-around of sequential PC
        fetch(64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 0, 0, 0, 0);
        look("wrap2");
        chk("wrap2.next_pc", next_pc, 64'h0);
        tick();
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 0, 0, 0, 0, 0);
        look("wrap1");
        chk("wrap1.next_pc", next_pc, 64'h0);
        tick();
        fetch(64'h1234, 64'h0, 0, 0, 0, 0, 0, 0);
        look("idle");
        chk("idle.next_pc", next_pc, 64'h1234);
        tick();

        // Randomized traffic against the reference table
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            fetch(rpc(), rpc(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) if_inst2_pc = if_inst1_pc + 64'd4;
            br(1'($urandom), 1'($urandom_range(0, 3) != 0), rpc(), {$urandom, $urandom},
               1'($urandom), 1'($urandom_range(0, 3) != 0), rpc(), {$urandom, $urandom});
            look("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
